// File: rtl/fc_window_ram.sv
// fc_window_ram: burst-loaded word store with a registered LANES-wide windowed read.
// Optional feature macro: FC_RAM_ZERO_PAD_EN (zero lanes at or above min(rd_count, LANES)).
`default_nettype none

module fc_window_ram #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 14,
   parameter int LANES  = 120,
   parameter int CNT_W  = $clog2(LANES + 1)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_start,
   input  logic [ADDR_W-1:0]         wr_base,
   input  logic [ADDR_W:0]           wr_len,
   input  logic                      wr_valid,
   input  logic [DATA_W-1:0]         wr_data,
   output logic                      wr_ready,
   output logic                      wr_done,
   input  logic                      rd_req,
   input  logic [ADDR_W-1:0]         rd_addr,
   input  logic [CNT_W-1:0]          rd_count,
   output logic                      rd_valid,
   output logic [LANES*DATA_W-1:0]   rd_data
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_LOAD = 1'b1
   } state_t;

   state_t                   state_q, state_d;
   logic [ADDR_W-1:0]        ptr_q, ptr_d;
   logic [ADDR_W:0]          remain_q, remain_d;
   logic                     wr_done_q, wr_done_d;
   logic                     rd_valid_q, rd_valid_d;
   logic [LANES*DATA_W-1:0]  rd_data_q, rd_data_d;
   logic                     mem_we;

   logic [DATA_W-1:0]        mem [DEPTH];

   // Loader: zero-length bursts complete straight from IDLE without entering LOAD.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      remain_d  = remain_q;
      wr_done_d = 1'b0;
      mem_we    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (wr_start) begin
               ptr_d    = wr_base;
               remain_d = wr_len;
               if (wr_len == '0) begin
                  wr_done_d = 1'b1;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            if (wr_valid) begin
               mem_we   = 1'b1;
               ptr_d    = ptr_q + ADDR_W'(1);
               remain_d = remain_q - (ADDR_W+1)'(1);
               if (remain_q == (ADDR_W+1)'(1)) begin
                  state_d   = S_IDLE;
                  wr_done_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef FC_RAM_ZERO_PAD_EN
   logic [CNT_W-1:0] rd_lim;
   assign rd_lim = (rd_count > CNT_W'(LANES)) ? CNT_W'(LANES) : rd_count;
`else
   logic unused_rd_count;
   assign unused_rd_count = ^rd_count;
`endif

   // Window read samples the array before this edge's write, giving old-data on collision.
   always_comb begin
      rd_valid_d = rd_req;
      rd_data_d  = rd_data_q;
      if (rd_req) begin
         for (int i = 0; i < LANES; i++) begin
`ifdef FC_RAM_ZERO_PAD_EN
            if (CNT_W'(i) < rd_lim) begin
               rd_data_d[i*DATA_W +: DATA_W] = mem[rd_addr + ADDR_W'(i)];
            end else begin
               rd_data_d[i*DATA_W +: DATA_W] = '0;
            end
`else
            rd_data_d[i*DATA_W +: DATA_W] = mem[rd_addr + ADDR_W'(i)];
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         remain_q   <= '0;
         wr_done_q  <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         remain_q   <= remain_d;
         wr_done_q  <= wr_done_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // Storage is deliberately not reset so a mid-burst reset keeps already-written words.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[ptr_q] <= wr_data;
      end
   end

   assign wr_ready = (state_q == S_LOAD);
   assign wr_done  = wr_done_q;
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;

endmodule

`default_nettype wire

// File: tb/tb_fc_window_ram.sv
// tb_fc_window_ram: directed, table-driven checks of fc_window_ram loading and window reads.
`default_nettype none

module tb_fc_window_ram;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 14;
   localparam int LANES  = 120;
   localparam int CNT_W  = 7;
`ifdef FC_RAM_ZERO_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     wr_start = 1'b0;
   logic [ADDR_W-1:0]        wr_base = '0;
   logic [ADDR_W:0]          wr_len = '0;
   logic                     wr_valid = 1'b0;
   logic [DATA_W-1:0]        wr_data = '0;
   logic                     wr_ready;
   logic                     wr_done;
   logic                     rd_req = 1'b0;
   logic [ADDR_W-1:0]        rd_addr = '0;
   logic [CNT_W-1:0]         rd_count = '0;
   logic                     rd_valid;
   logic [LANES*DATA_W-1:0]  rd_data;

   int checks = 0;
   int errors = 0;

   fc_window_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_start (wr_start),
      .wr_base  (wr_base),
      .wr_len   (wr_len),
      .wr_valid (wr_valid),
      .wr_data  (wr_data),
      .wr_ready (wr_ready),
      .wr_done  (wr_done),
      .rd_req   (rd_req),
      .rd_addr  (rd_addr),
      .rd_count (rd_count),
      .rd_valid (rd_valid),
      .rd_data  (rd_data)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got running want finished");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string             name;
      logic [ADDR_W-1:0] addr;
      logic [CNT_W-1:0]  cnt;
      int                lane;
      logic [15:0]       exp_pad;
      logic [15:0]       exp_raw;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] lane(input int i);
      return rd_data[i*DATA_W +: DATA_W];
   endfunction

   // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len);
      wr_start = 1'b1;
      wr_base  = base;
      wr_len   = len;
      tick();
      wr_start = 1'b0;
   endtask

   task automatic beat(input logic [DATA_W-1:0] d);
      wr_valid = 1'b1;
      wr_data  = d;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic read(input string name, input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] c);
      rd_req   = 1'b1;
      rd_addr  = a;
      rd_count = c;
      tick();
      rd_req = 1'b0;
      chk({name, " rd_valid"}, 32'(rd_valid), 32'd1);
   endtask

   initial begin
      vecs[0] = '{"v0_in_range_last",  14'd10,    7'd5,   4,   16'd14,     16'd14};
      vecs[1] = '{"v1_beyond_count",   14'd10,    7'd5,   5,   16'd0,      16'd15};
      vecs[2] = '{"v2_wrap_in_count",  14'd16383, 7'd2,   1,   16'hA004,   16'hA004};
      vecs[3] = '{"v3_wrap_past_cnt",  14'd16383, 7'd2,   2,   16'd0,      16'hA005};
      vecs[4] = '{"v4_clamp_127",      14'd0,     7'd127, 119, 16'd119,    16'd119};
      vecs[5] = '{"v5_count_zero",     14'd4,     7'd0,   0,   16'd0,      16'd4};
      vecs[6] = '{"v6_mid_window",     14'd100,   7'd120, 19,  16'd119,    16'd119};
      vecs[7] = '{"v7_wrap_lane6",     14'd16381, 7'd7,   6,   16'hA007,   16'hA007};

      // Reset state
      #3;
      chk("reset rd_data", 32'(rd_data == '0), 32'd1);
      chk("reset rd_valid", 32'(rd_valid), 32'd0);
      chk("reset wr_ready", 32'(wr_ready), 32'd0);
      chk("reset wr_done", 32'(wr_done), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Load 0..119 with data = index
      start(14'd0, 15'd120);
      chk("load1 wr_ready", 32'(wr_ready), 32'd1);
      for (int k = 0; k < 120; k++) beat(16'(k));
      chk("load1 wr_done", 32'(wr_done), 32'd1);
      chk("load1 wr_ready after", 32'(wr_ready), 32'd0);
      read("full", 14'd0, 7'd120);
      chk("load1 wr_done one cycle", 32'(wr_done), 32'd0);
      for (int i = 0; i < LANES; i++) chk($sformatf("full lane%0d", i), 32'(lane(i)), 32'(i));
      tick();
      chk("rd_valid single pulse", 32'(rd_valid), 32'd0);
      chk("rd_data held", 32'(lane(5)), 32'd5);

      // Wrapping burst across the top of the address space
      start(14'd16380, 15'd8);
      for (int k = 0; k < 8; k++) beat(16'hA000 + 16'(k));
      chk("wrap wr_done", 32'(wr_done), 32'd1);
      read("wrap", 14'd16380, 7'd8);
      for (int i = 0; i < 8; i++) chk($sformatf("wrap lane%0d", i), 32'(lane(i)), 32'(16'hA000 + 16'(i)));
      chk("wrap lane8", 32'(lane(8)), PAD ? 32'd0 : 32'd4);
      chk("wrap lane119", 32'(lane(119)), PAD ? 32'd0 : 32'd115);

      // Table-driven window reads
      for (int v = 0; v < 8; v++) begin
         read(vecs[v].name, vecs[v].addr, vecs[v].cnt);
         chk(vecs[v].name, 32'(lane(vecs[v].lane)), PAD ? 32'(vecs[v].exp_pad) : 32'(vecs[v].exp_raw));
      end

      // Zero-length burst; wr_valid in IDLE must not write
      wr_valid = 1'b1;
      wr_data  = 16'hFFFF;
      start(14'd10, 15'd0);
      chk("len0 wr_done", 32'(wr_done), 32'd1);
      chk("len0 wr_ready", 32'(wr_ready), 32'd0);
      tick();
      chk("len0 wr_done drop", 32'(wr_done), 32'd0);
      chk("len0 wr_ready stays", 32'(wr_ready), 32'd0);
      wr_valid = 1'b0;
      read("len0 mem", 14'd10, 7'd1);
      chk("len0 mem unchanged", 32'(lane(0)), 32'd10);

      // Stalled burst with an ignored wr_start during LOAD
      start(14'd300, 15'd4);
      beat(16'hB000);
      beat(16'hB001);
      for (int s = 0; s < 5; s++) begin
         if (s == 2) begin
            wr_start = 1'b1;
            wr_base  = 14'd10;
            wr_len   = 15'd1;
         end
         tick();
         wr_start = 1'b0;
         chk($sformatf("stall%0d wr_ready", s), 32'(wr_ready), 32'd1);
         chk($sformatf("stall%0d wr_done", s), 32'(wr_done), 32'd0);
      end
      beat(16'hB002);
      chk("stall pre-last wr_done", 32'(wr_done), 32'd0);
      beat(16'hB003);
      chk("stall wr_done", 32'(wr_done), 32'd1);
      // New burst accepted while wr_done is high
      start(14'd400, 15'd1);
      chk("b2b accepted", 32'(wr_ready), 32'd1);
      beat(16'hC000);
      chk("b2b wr_done", 32'(wr_done), 32'd1);
      read("stall data", 14'd300, 7'd4);
      for (int i = 0; i < 4; i++) chk($sformatf("stall lane%0d", i), 32'(lane(i)), 32'(16'hB000 + 16'(i)));
      read("ignored start", 14'd10, 7'd1);
      chk("ignored start mem", 32'(lane(0)), 32'd10);
      read("b2b data", 14'd400, 7'd1);
      chk("b2b mem", 32'(lane(0)), 32'hC000);

      // Read/write collision returns old data; next read sees new data
      start(14'd50, 15'd1);
      wr_valid = 1'b1;
      wr_data  = 16'h1234;
      read("collide", 14'd50, 7'd1);
      wr_valid = 1'b0;
      chk("collide old", 32'(lane(0)), 32'h0032);
      chk("collide wr_done", 32'(wr_done), 32'd1);
      read("after collide", 14'd50, 7'd1);
      chk("after collide new", 32'(lane(0)), 32'h1234);

      // Reset mid-burst
      start(14'd500, 15'd10);
      for (int k = 0; k < 3; k++) beat(16'hD000 + 16'(k));
      rst_n = 1'b0;
      #1;
      chk("rst wr_ready", 32'(wr_ready), 32'd0);
      chk("rst wr_done", 32'(wr_done), 32'd0);
      chk("rst rd_valid", 32'(rd_valid), 32'd0);
      tick();
      rst_n = 1'b1;
      wr_valid = 1'b1;
      wr_data  = 16'hEEEE;
      tick();
      chk("post rst wr_done", 32'(wr_done), 32'd0);
      chk("post rst wr_ready", 32'(wr_ready), 32'd0);
      wr_valid = 1'b0;
      read("post rst", 14'd500, 7'd3);
      for (int i = 0; i < 3; i++) chk($sformatf("post rst lane%0d", i), 32'(lane(i)), 32'(16'hD000 + 16'(i)));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fc_window_ram.md
# fc_window_ram

Parametrised weight/bias store for the fully-connected stage. Accepts an auto-incrementing burst load of DATA_W-bit words and serves a registered wide read of LANES consecutive words starting at any address. Reads are one clock and wrap modulo the depth. It sits between the external loader and the FC multiply-accumulate array, replacing the fixed 120 × 16-bit combinational window memory.

## Interface
- DATA_W, 16, word width in bits
- ADDR_W, 14, address width; depth = 2^ADDR_W words
- LANES, 120, words returned per read
- CNT_W, $clog2(LANES+1), width of rd_count
---
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_start  in  1  begin a burst load (accepted only in IDLE)
- wr_base  in  ADDR_W  first address of the burst
- wr_len  in  ADDR_W+1  number of words in the burst (0 … 2^ADDR_W)
- wr_valid  in  1  wr_data beat present
- wr_data  in  DATA_W  word to store
- wr_ready  out  1  high in LOAD; a beat is written when wr_valid && wr_ready
- wr_done  out  1  one-cycle pulse when a burst completes
- rd_req  in  1  read request
- rd_addr  in  ADDR_W  first word of the window
- rd_count  in  CNT_W  number of meaningful lanes
- rd_valid  out  1  one-cycle pulse; rd_data is new this cycle
- rd_data  out  LANES*DATA_W  lane i in bits [(i+1)*DATA_W-1 : i*DATA_W]

## Operation
- Loader FSM has two states, IDLE and LOAD.
- IDLE:
  - wr_start latches ptr=wr_base and remain=wr_len.
  - If wr_len==0, go to IDLE next cycle with a wr_done pulse; no write occurs.
  - Otherwise go to LOAD.
- LOAD:
  - wr_ready=1.
  - Each accepted beat does mem[ptr] <= wr_data, ptr <= ptr+1 (mod 2^ADDR_W), remain <= remain-1.
  - The beat that makes remain reach 0 returns the FSM to IDLE and pulses wr_done in the following cycle.
- wr_start during LOAD is ignored.
- wr_valid in IDLE is ignored; nothing is written.
- Read:
  - On rd_req, lane i is registered as mem[(rd_addr+i) mod 2^ADDR_W] for i < min(rd_count, LANES).
  - Lane i is registered as 0 for lanes at or above that limit (see Configuration).
  - rd_count > LANES is clamped to LANES.
- rd_data holds its value until the next rd_req. Reads are legal in either FSM state.
- Read/write collision in the same cycle to the same address: the read returns the old contents (read samples memory before the write edge).
- Memory contents are not reset and are undefined until written.

## Timing
- Reset state:
  - FSM = IDLE, ptr = 0, remain = 0.
  - wr_ready = 0, wr_done = 0, rd_valid = 0, rd_data = 0.
- Reset asserted mid-burst aborts the burst. No wr_done is issued. Words already written remain.
- Write latency: a word accepted at edge N is readable by an rd_req sampled at edge N+1.
- Read latency: rd_req sampled at edge N gives rd_valid=1 and new rd_data after edge N. rd_valid is high for exactly one cycle per request.
- Back-to-back rd_req is allowed every cycle.
- wr_done rises one cycle after the final accepted beat and lasts one cycle.
- A new wr_start is accepted in the same cycle wr_done is high.
- Throughput: one write beat per cycle.

## Configuration
- FC_RAM_ZERO_PAD_EN:
  - Defined: lanes at or above min(rd_count, LANES) are forced to 0.
  - Undefined: rd_count is ignored and all LANES lanes carry memory contents, including wrapped addresses.

## Test plan
- Reset, then load wr_base=0, wr_len=120 with data = index; rd_req rd_addr=0, rd_count=120 → one cycle later rd_valid=1 and lane i=i for all i. Before reset, rd_data=0.
- Load wr_base=16380, wr_len=8, data 0xA000+k; rd_addr=16380, rd_count=8 → lanes 0-3 = 0xA000-0xA003 (addr 16380-16383), lanes 4-7 = 0xA004-0xA007 (addr 0-3); lanes ≥8 = 0 with FC_RAM_ZERO_PAD_EN.
- wr_len=0 → wr_done pulses the cycle after wr_start, wr_ready never rises, memory unchanged.
- Stall wr_valid low for 5 cycles mid-burst → no writes during the stall, wr_done only after beat wr_len; wr_start issued during LOAD is ignored.
- Same-cycle write of 0x1234 to addr 50 (old 0x0032) with rd_req rd_addr=50 → lane 0 = 0x0032; the next read returns 0x1234.
- Assert rst_n low after 3 of 10 beats → FSM IDLE, wr_ready=0, no wr_done; the first 3 words remain readable.
